// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 3-bit XNOR LFSR stream.
// Self-seeds from data, locks after a run of matches, then flywheels.
module lfsr_seq_checker #(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [2:0]       in_data,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             stuck
);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  localparam logic [2:0] LOCKUP = 3'b111;
  localparam logic [2:0] LOCK_N = 3'(LOCK_COUNT);
  localparam logic [2:0] LOSS_N = 3'(LOSS_COUNT);

  state_t           state, state_n;
  logic [2:0]       expected, expected_n;
  logic [2:0]       match_cnt, match_n;
  logic [2:0]       miss_cnt, miss_n;
  logic             locked_n, pulse_n, stuck_n;
  logic [ERR_W-1:0] cnt_n;
  logic             err;

  function automatic logic [2:0] nxt(input logic [2:0] q);
    return {q[0] ~^ q[2], q[2], q[1]};
  endfunction

  always_comb begin
    state_n    = state;
    expected_n = expected;
    match_n    = match_cnt;
    miss_n     = miss_cnt;
    stuck_n    = stuck;
    err        = 1'b0;
    if (in_valid) begin
      stuck_n = (in_data == LOCKUP);
      unique case (state)
        SEARCH: begin
          if (in_data != LOCKUP) begin
            expected_n = nxt(in_data);
            match_n    = 3'd0;
            state_n    = VERIFY;
          end
        end
        VERIFY: begin
          if (in_data == LOCKUP) begin
            state_n = SEARCH;
            match_n = 3'd0;
          end else if (in_data == expected) begin
            match_n    = match_cnt + 3'd1;
            expected_n = nxt(in_data);
            if (match_cnt + 3'd1 == LOCK_N)
              state_n = LOCKED;
          end else begin
            expected_n = nxt(in_data);
            match_n    = 3'd0;
          end
        end
        LOCKED: begin
          // flywheel: prediction never reseeds from data here
          expected_n = nxt(expected);
          if (in_data == expected) begin
            miss_n = 3'd0;
          end else begin
            err    = 1'b1;
            miss_n = miss_cnt + 3'd1;
            if (miss_cnt + 3'd1 == LOSS_N) begin
              state_n = SEARCH;
              miss_n  = 3'd0;
            end
          end
        end
        default: state_n = SEARCH;
      endcase
    end
    pulse_n  = err;
    locked_n = (state_n == LOCKED);
    // an error coinciding with a clear still counts
    if (clear_cnt)
      cnt_n = err ? ERR_W'(1) : '0;
    else if (err && err_count != '1)
      cnt_n = err_count + ERR_W'(1);
    else
      cnt_n = err_count;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      expected  <= 3'd0;
      match_cnt <= 3'd0;
      miss_cnt  <= 3'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      stuck     <= 1'b0;
    end else begin
      state     <= state_n;
      expected  <= expected_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      locked    <= locked_n;
      err_pulse <= pulse_n;
      err_count <= cnt_n;
      stuck     <= stuck_n;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed vector table, hand sequences,
// and random stimulus against a cycle-table reference model.
module tb_lfsr_seq_checker;

  logic       clk = 1'b0;
  logic       rst, rst2;
  logic       in_valid, clear_cnt;
  logic [2:0] in_data;
  logic       locked, err_pulse, stuck;
  logic [7:0] err_count;
  logic       locked2, err_pulse2, stuck2;
  logic [1:0] err_count2;

  always #5 clk = ~clk;

  lfsr_seq_checker u_dut (
    .clk(clk), .reset(rst), .in_valid(in_valid),
    .in_data(in_data), .clear_cnt(clear_cnt),
    .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .stuck(stuck)
  );

  lfsr_seq_checker #(.LOCK_COUNT(3), .LOSS_COUNT(7), .ERR_W(2)) u_dut2 (
    .clk(clk), .reset(rst2), .in_valid(in_valid),
    .in_data(in_data), .clear_cnt(clear_cnt),
    .locked(locked2), .err_pulse(err_pulse2),
    .err_count(err_count2), .stuck(stuck2)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // legal sequence, one lap of the period-7 cycle
  int cyc [7] = '{0, 4, 2, 5, 6, 3, 1};

  typedef struct {
    int mode;
    int ex;
    int mt;
    int ms;
    int cnt;
    bit lk;
    bit p;
    bit s;
  } model_t;

  model_t m1, m2;

  function automatic int pos(input logic [2:0] d);
    for (int i = 0; i < 7; i++)
      if (cyc[i] == int'(d)) return i;
    return -1;
  endfunction

  function automatic model_t mstep(input model_t m, input bit v,
                                   input logic [2:0] d, input bit c,
                                   input int lockc, input int lossc,
                                   input int maxc);
    model_t r;
    int p;
    bit e;
    r = m;
    r.p = 0;
    e = 0;
    if (v) begin
      r.s = (d == 3'b111);
      p = pos(d);
      if (m.mode == 0) begin
        if (p >= 0) begin
          r.ex = (p + 1) % 7;
          r.mt = 0;
          r.mode = 1;
        end
      end else if (m.mode == 1) begin
        if (p < 0) begin
          r.mode = 0;
          r.mt = 0;
        end else if (p == m.ex) begin
          r.mt = m.mt + 1;
          r.ex = (p + 1) % 7;
          if (r.mt == lockc) r.mode = 2;
        end else begin
          r.ex = (p + 1) % 7;
          r.mt = 0;
        end
      end else begin
        r.ex = (m.ex + 1) % 7;
        if (p == m.ex) r.ms = 0;
        else begin
          e = 1;
          r.p = 1;
          r.ms = m.ms + 1;
          if (r.ms == lossc) begin
            r.mode = 0;
            r.ms = 0;
          end
        end
      end
    end
    if (c) r.cnt = e ? 1 : 0;
    else if (e && r.cnt < maxc) r.cnt = r.cnt + 1;
    r.lk = (r.mode == 2);
    return r;
  endfunction

  typedef struct {
    bit         rst;
    bit         v;
    logic [2:0] d;
    bit         c;
    bit         l;
    bit         p;
    int         cnt;
    bit         s;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit v, input logic [2:0] d,
                     input bit c, input bit l, input bit p,
                     input int cnt, input bit s);
    vec_t x;
    x.rst = r; x.v = v; x.d = d; x.c = c;
    x.l = l; x.p = p; x.cnt = cnt; x.s = s;
    tbl.push_back(x);
  endtask

  task automatic drive(input bit v, input logic [2:0] d, input bit c);
    in_valid = v;
    in_data = d;
    clear_cnt = c;
    @(posedge clk);
    #1;
  endtask

  // asynchronous: checked before any further clock edge
  task automatic do_reset();
    rst = 1'b1;
    rst2 = 1'b1;
    in_valid = 1'b0;
    clear_cnt = 1'b0;
    #3;
    check("rst locked", 32'(locked), 0);
    check("rst err_pulse", 32'(err_pulse), 0);
    check("rst err_count", 32'(err_count), 0);
    check("rst stuck", 32'(stuck), 0);
    check("rst2 locked", 32'(locked2), 0);
    check("rst2 err_count", 32'(err_count2), 0);
    rst = 1'b0;
    rst2 = 1'b0;
    m1 = '{default: 0};
    m2 = '{default: 0};
  endtask

  task automatic cmp_model(input string tag, input model_t a,
                           input model_t b);
    check({tag, " locked"}, 32'(locked), 32'(a.lk));
    check({tag, " err_pulse"}, 32'(err_pulse), 32'(a.p));
    check({tag, " err_count"}, 32'(err_count), a.cnt);
    check({tag, " stuck"}, 32'(stuck), 32'(a.s));
    check({tag, " locked2"}, 32'(locked2), 32'(b.lk));
    check({tag, " err_pulse2"}, 32'(err_pulse2), 32'(b.p));
    check({tag, " err_count2"}, 32'(err_count2), b.cnt);
    check({tag, " stuck2"}, 32'(stuck2), 32'(b.s));
  endtask

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    in_valid = 1'b0;
    in_data = 3'd0;
    clear_cnt = 1'b0;

    // rst, v, d, c | locked, pulse, count, stuck
    add(1, 0, 3'd0, 0, 0, 0, 0, 0);
    add(0, 1, 3'd0, 0, 0, 0, 0, 0);
    add(0, 1, 3'd4, 0, 0, 0, 0, 0);
    add(0, 1, 3'd2, 0, 0, 0, 0, 0);
    add(0, 1, 3'd5, 0, 1, 0, 0, 0);
    add(0, 1, 3'd6, 0, 1, 0, 0, 0);
    add(0, 0, 3'd7, 0, 1, 0, 0, 0);
    add(0, 1, 3'd3, 0, 1, 0, 0, 0);
    add(0, 0, 3'd7, 0, 1, 0, 0, 0);
    add(0, 1, 3'd1, 0, 1, 0, 0, 0);
    add(0, 0, 3'd7, 0, 1, 0, 0, 0);
    add(0, 1, 3'd0, 0, 1, 0, 0, 0);
    add(0, 0, 3'd7, 0, 1, 0, 0, 0);
    add(0, 1, 3'd4, 0, 1, 0, 0, 0);
    add(0, 1, 3'd2, 0, 1, 0, 0, 0);
    add(0, 1, 3'd5, 0, 1, 0, 0, 0);
    add(0, 1, 3'd6, 0, 1, 0, 0, 0);
    add(0, 1, 3'd7, 0, 1, 1, 1, 1);
    add(0, 1, 3'd1, 0, 1, 0, 1, 0);
    add(0, 0, 3'd0, 1, 1, 0, 0, 0);
    add(0, 1, 3'd2, 0, 1, 1, 1, 0);
    add(0, 1, 3'd2, 0, 0, 1, 2, 0);
    add(0, 1, 3'd1, 0, 0, 0, 2, 0);
    add(0, 1, 3'd0, 0, 0, 0, 2, 0);
    add(0, 1, 3'd4, 0, 0, 0, 2, 0);
    add(0, 1, 3'd2, 0, 1, 0, 2, 0);
    add(1, 0, 3'd0, 0, 0, 0, 0, 0);
    add(0, 1, 3'd7, 0, 0, 0, 0, 1);
    add(0, 1, 3'd7, 0, 0, 0, 0, 1);
    add(0, 1, 3'd4, 0, 0, 0, 0, 0);
    add(0, 1, 3'd5, 0, 0, 0, 0, 0);
    add(0, 1, 3'd2, 0, 0, 0, 0, 0);
    add(0, 1, 3'd5, 0, 0, 0, 0, 0);
    add(0, 1, 3'd6, 0, 0, 0, 0, 0);
    add(0, 1, 3'd3, 0, 1, 0, 0, 0);

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      else drive(tbl[i].v, tbl[i].d, tbl[i].c);
      check($sformatf("vec%0d locked", i), 32'(locked), 32'(tbl[i].l));
      check($sformatf("vec%0d err_pulse", i), 32'(err_pulse),
            32'(tbl[i].p));
      check($sformatf("vec%0d err_count", i), 32'(err_count),
            tbl[i].cnt);
      check($sformatf("vec%0d stuck", i), 32'(stuck), 32'(tbl[i].s));
    end

    // narrow counter saturation, clear racing an error, async reset
    rst2 = 1'b1;
    #3;
    rst2 = 1'b0;
    drive(1, 3'd0, 0);
    drive(1, 3'd4, 0);
    drive(1, 3'd2, 0);
    drive(1, 3'd5, 0);
    check("sat lock", 32'(locked2), 1);
    for (int k = 1; k <= 5; k++) begin
      drive(1, 3'd7, 0);
      check($sformatf("sat err%0d count", k), 32'(err_count2),
            32'((k > 3) ? 3 : k));
      check($sformatf("sat err%0d pulse", k), 32'(err_pulse2), 1);
      check($sformatf("sat err%0d locked", k), 32'(locked2), 1);
    end
    drive(1, 3'd7, 1);
    check("clr+err count", 32'(err_count2), 1);
    check("clr+err pulse", 32'(err_pulse2), 1);
    check("clr+err locked", 32'(locked2), 1);
    in_valid = 1'b0;
    clear_cnt = 1'b0;
    @(negedge clk);
    rst2 = 1'b1;
    #1;
    check("async locked2", 32'(locked2), 0);
    check("async count2", 32'(err_count2), 0);
    check("async pulse2", 32'(err_pulse2), 0);
    rst2 = 1'b0;
    @(posedge clk);
    #1;

    // random traffic against both reference models
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit v, c;
      logic [2:0] d;
      r = int'($urandom_range(0, 99));
      v = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 49) == 0);
      if (m1.mode != 0 && r < 75) d = 3'(cyc[m1.ex]);
      else if (r >= 90) d = 3'b111;
      else d = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        drive(v, d, c);
        m1 = mstep(m1, v, d, c, 3, 2, 255);
        m2 = mstep(m2, v, d, c, 3, 7, 3);
        cmp_model($sformatf("rnd%0d", n), m1, m2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
